// File: rtl/w80386dx_tlb_pkg.sv
// rtl/w80386dx_tlb_pkg.sv - shared types, field positions and helpers for the TLB test engine
package w80386dx_tlb_pkg;

    localparam int DEF_SET_BITS = 3;
    localparam int PA_W         = 20;

    // TR6 field positions
    localparam int TR6_C        = 0;
    localparam int TR6_WN       = 5;
    localparam int TR6_W        = 6;
    localparam int TR6_UN       = 7;
    localparam int TR6_U        = 8;
    localparam int TR6_DN       = 9;
    localparam int TR6_D        = 10;
    localparam int TR6_V        = 11;
    localparam int TR6_SET_LSB  = 12;

    // TR7 field positions
    localparam int TR7_REP_LSB  = 2;
    localparam int TR7_HT       = 4;
    localparam int TR7_PA_LSB   = 12;

    // One TLB entry at the default geometry, MSB to LSB
    typedef struct packed {
        logic                     v;
        logic [19-DEF_SET_BITS:0] tag;
        logic                     d;
        logic                     u;
        logic                     w;
        logic [PA_W-1:0]          pa;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_LOOKUP,
        ST_RESULT
    } tlb_state_e;

    // A (bit, bit#) request pair: 10 needs a set bit, 01 a clear bit, 00/11 match anything
    function automatic logic attr_ok(input logic want, input logic want_n, input logic ebit);
        case ({want, want_n})
            2'b10:   return ebit;
            2'b01:   return !ebit;
            default: return 1'b1;
        endcase
    endfunction

    // Lookup result in TR7 layout
    function automatic logic [31:0] tr7_result(input logic [PA_W-1:0] pa, input logic ht,
                                               input logic [1:0] rep);
        logic [31:0] r;
        r = '0;
        r[31:TR7_PA_LSB]       = pa;
        r[TR7_HT]              = ht;
        r[TR7_REP_LSB +: 2]    = rep;
        return r;
    endfunction

endpackage

// File: rtl/tlb_test_engine_if.sv
// rtl/tlb_test_engine_if.sv - command, TLB array and TR7 write-back signals of the test engine
interface tlb_test_engine_if
    import w80386dx_tlb_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS
) ();
    localparam int ENTRY_W = 44 - SET_BITS;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [31:0]         tr6;
    logic [31:0]         tr7;
    logic                tlb_req;
    logic                tlb_we;
    logic [SET_BITS-1:0] tlb_set;
    logic [1:0]          tlb_way;
    logic [ENTRY_W-1:0]  tlb_wdata;
    logic                tlb_ack;
    logic [ENTRY_W-1:0]  tlb_rdata;
    logic                tr7_we;
    logic [31:0]         tr7_wdata;
    logic                busy;

    modport master (
        input  cmd_valid, tr6, tr7, tlb_ack, tlb_rdata,
        output cmd_ready, tlb_req, tlb_we, tlb_set, tlb_way, tlb_wdata,
               tr7_we, tr7_wdata, busy
    );

    modport slave (
        output cmd_valid, tr6, tr7, tlb_ack, tlb_rdata,
        input  cmd_ready, tlb_req, tlb_we, tlb_set, tlb_way, tlb_wdata,
               tr7_we, tr7_wdata, busy
    );
endinterface

// File: rtl/tlb_test_match.sv
// rtl/tlb_test_match.sv - combinational hit compare of a lookup command against one entry
module tlb_test_match
    import w80386dx_tlb_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS
) (
    input  logic [19-SET_BITS:0] tag,   // command tag
    input  logic [5:0]           attr,  // {D, D#, U, U#, W, W#} from TR6
    input  logic [23-SET_BITS:0] hdr,   // entry without PA: {V, TAG, D, U, W}
    output logic                 hit
);
    // Valid, tag equal, and every attribute pair satisfied
    always_comb begin
        hit = hdr[23-SET_BITS]
            && (hdr[22-SET_BITS:3] == tag)
            && attr_ok(attr[5], attr[4], hdr[2])
            && attr_ok(attr[3], attr[2], hdr[1])
            && attr_ok(attr[1], attr[0], hdr[0]);
    end
endmodule

// File: rtl/tlb_test_engine.sv
// rtl/tlb_test_engine.sv - executes TR6/TR7 TLB write and lookup commands against the TLB array
module tlb_test_engine
    import w80386dx_tlb_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS
) (
    input  logic              clock,
    input  logic              reset,
    tlb_test_engine_if.master bus
);
    localparam int TAG_W   = 20 - SET_BITS;
    localparam int ENTRY_W = 4 + TAG_W + PA_W;
    localparam int TAG_LSB = TR6_SET_LSB + SET_BITS;

    tlb_state_e       state_q, state_d;
    logic [31:TR6_WN] tr6_q, tr6_d;       // bits below W# are never used after accept
    logic [PA_W-1:0]  pa_q, pa_d;         // TR7 PA field for writes
    logic [1:0]       wr_way_q, wr_way_d; // TR7 way field for writes
    logic [1:0]       way_q, way_d;       // lookup probe counter
    logic [31:0]      res_q, res_d;       // pending TR7 write-back value
    logic             hit;

    tlb_test_match #(.SET_BITS(SET_BITS)) u_match (
        .tag  (tr6_q[31:TAG_LSB]),
        .attr ({tr6_q[TR6_D], tr6_q[TR6_DN], tr6_q[TR6_U],
                tr6_q[TR6_UN], tr6_q[TR6_W], tr6_q[TR6_WN]}),
        .hdr  (bus.tlb_rdata[ENTRY_W-1:PA_W]),
        .hit  (hit)
    );

    // Command capture, way probing and result assembly
    always_comb begin
        state_d  = state_q;
        tr6_d    = tr6_q;
        pa_d     = pa_q;
        wr_way_d = wr_way_q;
        way_d    = way_q;
        res_d    = res_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    tr6_d    = bus.tr6[31:TR6_WN];
                    pa_d     = bus.tr7[31:TR7_PA_LSB];
                    wr_way_d = bus.tr7[TR7_REP_LSB +: 2];
                    way_d    = 2'd0;
                    state_d  = bus.tr6[TR6_C] ? ST_LOOKUP : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.tlb_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (bus.tlb_ack) begin
                    if (hit) begin
                        res_d   = tr7_result(bus.tlb_rdata[PA_W-1:0], 1'b1, way_q);
                        state_d = ST_RESULT;
                    end else if (way_q == 2'd3) begin
                        res_d   = tr7_result('0, 1'b0, 2'd0);
                        state_d = ST_RESULT;
                    end else begin
                        way_d = way_q + 2'd1;
                    end
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured command registers; reset aborts any access in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            tr6_q    <= '0;
            pa_q     <= '0;
            wr_way_q <= '0;
            way_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            tr6_q    <= tr6_d;
            pa_q     <= pa_d;
            wr_way_q <= wr_way_d;
            way_q    <= way_d;
            res_q    <= res_d;
        end
    end

    // Outputs decode straight from the state so reset drops the request at once
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.tlb_req   = (state_q == ST_WRITE) || (state_q == ST_LOOKUP);
    assign bus.tlb_we    = (state_q == ST_WRITE);
    assign bus.tlb_set   = tr6_q[TR6_SET_LSB +: SET_BITS];
    assign bus.tlb_way   = (state_q == ST_WRITE) ? wr_way_q : way_q;
    assign bus.tlb_wdata = {tr6_q[TR6_V], tr6_q[31:TAG_LSB], tr6_q[TR6_D],
                            tr6_q[TR6_U], tr6_q[TR6_W], pa_q};
    assign bus.tr7_we    = (state_q == ST_RESULT);
    assign bus.tr7_wdata = res_q;

endmodule

// File: tb/tb_tlb_test_engine.sv
// tb/tb_tlb_test_engine.sv - self-checking bench for tlb_test_engine
module tb_tlb_test_engine;
    import w80386dx_tlb_pkg::*;

    localparam int SB = 3;
    localparam int EW = 44 - SB;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    tlb_test_engine_if #(.SET_BITS(SB)) bus ();
    tlb_test_engine #(.SET_BITS(SB)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic          we;
        logic [SB-1:0] set;
        logic [1:0]    way;
        logic [EW-1:0] wdata;
    } acc_t;

    typedef struct {
        logic [31:0]   tr6;
        logic [31:0]   tr7;
        logic [31:0]   exp_tr7;
        int            exp_acc;
        logic [1:0]    exp_way;
        logic [EW-1:0] exp_wdata;
    } vec_t;

    acc_t        acc_q[$];
    logic [31:0] exp_q[$];
    tlb_entry_t  mem [8][4];
    int          total = 0;
    int          bad = 0;
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    int          tr7_we_cnt = 0;
    bit          abort_ok = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_we = 1'b0;
    logic [SB-1:0] prev_set = '0;
    logic [1:0]  prev_way = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // TLB array model: acks after wait_cycles, logs each completed access
    always @(negedge clock) begin
        if (reset && !abort_ok && prev_req && !bus.tlb_ack) begin
            check("req_held_until_ack", bus.tlb_req, 1'b1);
            check("addr_stable", {bus.tlb_we, bus.tlb_set, bus.tlb_way},
                  {prev_we, prev_set, prev_way});
        end
        prev_req = bus.tlb_req;
        prev_we  = bus.tlb_we;
        prev_set = bus.tlb_set;
        prev_way = bus.tlb_way;
        if (bus.tlb_req) begin
            if (wait_cnt >= wait_cycles) begin
                bus.tlb_ack   = 1'b1;
                bus.tlb_rdata = mem[bus.tlb_set][bus.tlb_way];
                acc_q.push_back('{bus.tlb_we, bus.tlb_set, bus.tlb_way, bus.tlb_wdata});
                if (bus.tlb_we) mem[bus.tlb_set][bus.tlb_way] = bus.tlb_wdata;
                wait_cnt = 0;
            end else begin
                bus.tlb_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.tlb_ack = 1'b0;
            wait_cnt    = 0;
        end
    end

    // Scoreboard: every TR7 write-back must match the oldest expected result
    always @(negedge clock) begin
        if (bus.tr7_we) begin
            tr7_we_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_tr7_write", 1'b1, 1'b0);
            end else begin
                check("tr7_wdata", bus.tr7_wdata, exp_q.pop_front());
            end
        end
    end

    // Issue one command, optionally holding cmd_valid for `hold` busy cycles, and wait for idle
    task automatic run_cmd(input logic [31:0] t6, input logic [31:0] t7,
                           input logic [31:0] exp_tr7, input int hold, output int cycles);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("ready_before_cmd", bus.cmd_ready, 1'b1);
        acc_q.delete();
        if (t6[0]) exp_q.push_back(exp_tr7);
        bus.tr6 = t6;
        bus.tr7 = t7;
        bus.cmd_valid = 1'b1;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        check("busy_after_accept", {bus.busy, bus.cmd_ready}, 2'b10);
        cycles = 1;
        while (bus.busy && cycles < 300) begin
            bus.cmd_valid = (cycles <= hold);
            bus.tr6 = 32'h0000_3800;
            @(negedge clock);
            cycles++;
        end
        bus.cmd_valid = 1'b0;
        cycles--;
        check("cmd_completes", bus.busy, 1'b0);
    endtask

    function automatic logic [EW-1:0] ent(input logic v, input logic [16:0] tag, input logic d,
                                          input logic u, input logic w, input logic [19:0] pa);
        tlb_entry_t e;
        e = '{v: v, tag: tag, d: d, u: u, w: w, pa: pa};
        return e;
    endfunction

    vec_t vecs[9];
    int   cyc;
    int   base;
    int   n;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.tr6 = '0;
        bus.tr7 = '0;
        bus.tlb_ack = 1'b0;
        bus.tlb_rdata = '0;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++)
                mem[s][w] = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready_busy", {bus.cmd_ready, bus.busy}, 2'b10);
        reset = 1'b1;
        @(negedge clock);
        check("rst_req_we", {bus.tlb_req, bus.tlb_we, bus.tr7_we}, 3'b000);
        check("rst_set_way", {bus.tlb_set, bus.tlb_way}, '0);
        check("rst_wdata", bus.tlb_wdata, '0);
        check("rst_tr7_wdata", bus.tr7_wdata, '0);
        check("rst_ready_after", bus.cmd_ready, 1'b1);

        // Write command into set 3, way 3
        base = tr7_we_cnt;
        run_cmd(32'h0000_3800, 32'h1234_500C, 32'h0, 0, cyc);
        check("wr_latency", cyc, 1);
        check("wr_access_count", acc_q.size(), 1);
        if (acc_q.size() > 0) begin
            check("wr_we_set_way", {acc_q[0].we, acc_q[0].set, acc_q[0].way}, {1'b1, 3'd3, 2'd3});
            check("wr_entry", acc_q[0].wdata, ent(1'b1, 17'd0, 1'b0, 1'b0, 1'b0, 20'h12345));
        end
        check("wr_no_tr7_write", tr7_we_cnt - base, 0);

        // Set 3 contents for the lookup table
        mem[3][0] = ent(1'b0, 17'd0, 1'b1, 1'b1, 1'b1, 20'h55555);
        mem[3][1] = ent(1'b1, 17'd1, 1'b1, 1'b1, 1'b1, 20'h22222);
        mem[3][2] = ent(1'b1, 17'd0, 1'b1, 1'b0, 1'b1, 20'hABCDE);
        mem[3][3] = ent(1'b1, 17'd0, 1'b1, 1'b0, 1'b0, 20'h11111);

        vecs[0] = '{32'h0000_3801, 32'h0, 32'hABCD_E018, 3, 2'd0, '0};
        vecs[1] = '{32'h0000_3A01, 32'h0, 32'h0000_0000, 4, 2'd0, '0};
        vecs[2] = '{32'h0000_3FE1, 32'h0, 32'hABCD_E018, 3, 2'd0, '0};
        vecs[3] = '{32'h0000_3481, 32'h0, 32'hABCD_E018, 3, 2'd0, '0};
        vecs[4] = '{32'h0000_3021, 32'h0, 32'h1111_101C, 4, 2'd0, '0};
        vecs[5] = '{32'h0000_3101, 32'h0, 32'h0000_0000, 4, 2'd0, '0};
        vecs[6] = '{32'h0001_3001, 32'h0, 32'h0000_0000, 4, 2'd0, '0};
        vecs[7] = '{32'h0000_EE40, 32'hFEDC_B004, 32'h0, 1, 2'd1,
                    ent(1'b1, 17'd1, 1'b1, 1'b0, 1'b1, 20'hFEDCB)};
        vecs[8] = '{32'h0000_E401, 32'h0, 32'hFEDC_B014, 2, 2'd0, '0};

        for (int i = 0; i < 9; i++) begin
            base = tr7_we_cnt;
            run_cmd(vecs[i].tr6, vecs[i].tr7, vecs[i].exp_tr7, 0, cyc);
            check($sformatf("v%0d_latency", i), cyc,
                  vecs[i].tr6[0] ? vecs[i].exp_acc + 1 : 1);
            check($sformatf("v%0d_access_count", i), acc_q.size(), vecs[i].exp_acc);
            check($sformatf("v%0d_tr7_writes", i), tr7_we_cnt - base, vecs[i].tr6[0] ? 1 : 0);
            for (int a = 0; a < acc_q.size(); a++) begin
                if (vecs[i].tr6[0]) begin
                    check($sformatf("v%0d_probe%0d", i, a), {acc_q[a].we, acc_q[a].set, acc_q[a].way},
                          {1'b0, vecs[i].tr6[14:12], 2'(a)});
                end else begin
                    check($sformatf("v%0d_write_addr", i), {acc_q[a].we, acc_q[a].set, acc_q[a].way},
                          {1'b1, vecs[i].tr6[14:12], vecs[i].exp_way});
                    check($sformatf("v%0d_write_entry", i), acc_q[a].wdata, vecs[i].exp_wdata);
                end
            end
        end

        // Backpressure: 5 wait cycles per access, cmd_valid held while busy
        wait_cycles = 5;
        base = tr7_we_cnt;
        run_cmd(32'h0000_3801, 32'h0, 32'hABCD_E018, 10, cyc);
        check("bp_latency", cyc, 19);
        repeat (5) @(negedge clock);
        check("bp_access_count", acc_q.size(), 3);
        check("bp_tr7_writes", tr7_we_cnt - base, 1);
        check("bp_idle_after", {bus.cmd_ready, bus.tlb_req}, 2'b10);

        // Reset during the way-1 probe
        wait_cycles = 3;
        base = tr7_we_cnt;
        bus.tr6 = 32'h0000_3801;
        bus.cmd_valid = 1'b1;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!(bus.tlb_req && bus.tlb_way == 2'd1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("abort_reached_way1", {bus.tlb_req, bus.tlb_way}, {1'b1, 2'd1});
        abort_ok = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("abort_req_drop", bus.tlb_req, 1'b0);
        check("abort_ready_in_reset", bus.cmd_ready, 1'b1);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        repeat (6) @(negedge clock);
        abort_ok = 1'b0;
        check("abort_no_tr7_write", tr7_we_cnt - base, 0);
        check("abort_ready_after", {bus.cmd_ready, bus.busy, bus.tlb_req}, 3'b100);

        // Recovery after abort
        wait_cycles = 0;
        run_cmd(32'h0000_3801, 32'h0, 32'hABCD_E018, 0, cyc);
        check("recover_latency", cyc, 4);
        repeat (3) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
